alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised successor to the fixed 8×16 register-file ALU. The data path is generic in word width and register count. Issue uses a valid/ready handshake, and an iterative multi-cycle multiplier keeps the single-cycle critical path short. Arithmetic sets overflow/zero/negative flags. An external load/read port lets the CPU sequencer move data in and out of the register file.

## Interface
- WIDTH, 16, data word width; power of two, ≥4
- NREGS, 8, register count; power of two, ≥2
- AW, $clog2(NREGS), register index width (derived, not overridden)
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
- CLK  in  1  single clock; all state updates on posedge
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation this cycle
- op  in  4  opcode (see Operation)
- aindex  in  AW  operand A register
- bindex  in  AW  operand B register
- yindex  in  AW  destination register
- shamt  in  SHW  shift amount
- done  out  1  one-cycle pulse: operation retired
- result  out  WIDTH  last value written back; holds until the next write-back
- overflow  out  1  sticky overflow flag
- zero  out  1  last write-back value == 0
- negative  out  1  last write-back value MSB
- ext_we  in  1  external register write enable
- ext_windex  in  AW  external write index
- ext_wdata  in  WIDTH  external write data
- ext_rindex  in  AW  external read index
- ext_rdata  out  WIDTH  combinational read of rf[ext_rindex]

## Operation
- Opcodes:
  - 0 NOP
  - 1 ADD a+b
  - 2 SUB a−b
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT a
  - 7 SHL a<<shamt
  - 8 SHR logical
  - 9 ASR arithmetic
  - A MUL low WIDTH bits of a*b, unsigned
  - B CLRF clears overflow
  - C–F behave as NOP
- Accept on a posedge with in_valid && in_ready. Operands are read from the register file combinationally at the accept edge.
- FSM has two states:
  - IDLE: in_ready=1.
  - MUL: in_ready=0; entered on an accepted MUL.
- Single-cycle ops (1–9): rf[yindex], result and flags update at the accept edge. done=1 in the following cycle.
- NOP and CLRF: no register write, zero/negative unchanged, done pulses as for single-cycle ops.
- MUL:
  - Operands are latched at accept, so later register-file writes do not affect the product.
  - Shift-add runs for exactly WIDTH cycles in the MUL state.
  - Write-back and flag updates happen at the edge ending the last MUL cycle. The FSM returns to IDLE at that same edge, so done=1 and in_ready=1 in the next cycle.
- Overflow is set as follows and otherwise holds:
  - ADD: set on carry-out.
  - SUB: set on borrow (a<b unsigned).
  - MUL: set if the upper WIDTH bits of the product are nonzero.
  - Logic and shift ops leave overflow unchanged.
  - Cleared only by CLRF or RST. If a flag-setting op and CLRF would act on the same edge, the later-issued op applies, since only one op retires per edge.
- Write conflict: ext_we to the same register on the same edge as an ALU write-back → the ALU value wins. Writes to different registers both occur.
- ext_we is honoured in every state, including MUL.
- in_valid during MUL is ignored. The requester must hold the request until in_ready.

## Timing
- Reset values:
  - all rf = 0
  - result = 0
  - overflow, zero, negative, done = 0
  - in_ready = 1
  - FSM = IDLE
- Latency from accept edge to done high:
  - 1 cycle for every op except MUL.
  - WIDTH+1 cycles for MUL.
- Throughput: one single-cycle op per cycle. Back-to-back dependent ops see the written value, because the register file is updated at the accept edge.
- RST during MUL aborts with no write-back and no done pulse, and returns the block to reset state.
- ext_rdata reflects an ext_we or ALU write in the cycle after the write edge.

## Structure
- Shared package alu_pkg holds:
  - the opcode localparams (OP_NOP…OP_CLRF)
  - the FSM state typedef
  - flag bit positions
- Sub-module alu_mul_iter: iterative WIDTH-cycle unsigned shift-add multiplier.
  - Ports: start, a, b → busy, done, product[2*WIDTH-1:0].
  - Reset: same CLK/RST convention as the parent.
- The top level holds the register file, single-cycle datapath, flags and FSM.

## Test plan
- Reset: after RST, ext_rdata=0 for every index, overflow=0, in_ready=1, done=0.
- ADD/CLRF: ext load r1=0xFFFF, r2=0x0001; ADD y=3 → r3=0x0000, overflow=1, zero=1, done 1 cycle later; CLRF → overflow=0, r3 unchanged.
- SUB: r5=5, r6=7; SUB a=5 b=6 y=7 → r7=0xFFFE, negative=1, overflow=1.
- Shifts: SHL 0x0001 by 15 → 0x8000; SHR 0x8000 by 3 → 0x1000; ASR 0x8000 by 3 → 0xF000; overflow unchanged.
- MUL:
  - 3*5 → 15 with overflow unchanged.
  - 0x0100*0x0100 → 0x0000 with overflow=1.
  - in_ready low for exactly 16 cycles; a held in_valid is not accepted during that time.
  - Overwriting an operand register mid-MUL does not change the product.
- Conflict/reset:
  - ext_we writes 0x1234 to r4 on the same edge that ADD writes r4 → r4 = ADD result.
  - RST asserted mid-MUL → no done pulse, all rf=0, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential register-file ALU: opcodes,
// controller state encoding and flag bit positions.
package alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_ASR  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_CLRF = 4'hB;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int FLAG_OV = 0;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_N  = 2;
  localparam int NFLAGS  = 3;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier. One partial product per cycle,
// WIDTH cycles per multiply. 'done' and 'product' are combinational so the
// parent can write back the finished product on the edge that ends the
// final step, without an extra cycle.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  logic                 r_busy;
  logic [SHW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   w_partial;
  logic [2*WIDTH-1:0]   w_accNext;

  assign w_partial = r_mplier[0] ? r_mcand : '0;
  assign w_accNext = r_acc + w_partial;

  // Latch operands on start, then add one shifted partial product per cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (start && !r_busy) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
    end else if (r_busy) begin
      r_acc    <= w_accNext;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == LAST_STEP) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == LAST_STEP);
  assign product = w_accNext;

endmodule

// File: rtl/alu_seq.sv
// Register-file ALU with valid/ready issue, single-cycle arithmetic/logic
// ops, an iterative multiplier, sticky overflow and an external load/read
// port for the sequencer.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 op,
  input  logic [$clog2(NREGS)-1:0]   aindex,
  input  logic [$clog2(NREGS)-1:0]   bindex,
  input  logic [$clog2(NREGS)-1:0]   yindex,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic                       overflow,
  output logic                       zero,
  output logic                       negative,
  input  logic                       ext_we,
  input  logic [$clog2(NREGS)-1:0]   ext_windex,
  input  logic [WIDTH-1:0]           ext_wdata,
  input  logic [$clog2(NREGS)-1:0]   ext_rindex,
  output logic [WIDTH-1:0]           ext_rdata
);

  import alu_pkg::*;

  localparam int AW = $clog2(NREGS);

  state_t               r_state;
  state_t               w_stateNext;
  logic [WIDTH-1:0]     r_rf [NREGS];
  logic [WIDTH-1:0]     r_result;
  logic [NFLAGS-1:0]    r_flags;
  logic                 r_done;
  logic [AW-1:0]        r_mulY;

  logic                 w_accept;
  logic                 w_mulStart;
  logic                 w_mulBusy;
  logic                 w_mulDone;
  logic [2*WIDTH-1:0]   w_product;
  logic [WIDTH-1:0]     w_opA;
  logic [WIDTH-1:0]     w_opB;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic                 w_aluWe;
  logic [WIDTH-1:0]     w_aluData;
  logic                 w_aluOvSet;
  logic                 w_wbEn;
  logic [AW-1:0]        w_wbIdx;
  logic [WIDTH-1:0]     w_wbData;
  logic                 w_ovSet;
  logic                 w_ovClr;

  assign in_ready   = (r_state == ST_IDLE) && !w_mulBusy;
  assign w_accept   = in_valid && in_ready;
  assign w_mulStart = w_accept && (op == OP_MUL);

  assign w_opA  = r_rf[aindex];
  assign w_opB  = r_rf[bindex];
  assign w_sum  = {1'b0, w_opA} + {1'b0, w_opB};
  assign w_diff = {1'b0, w_opA} - {1'b0, w_opB};

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .CLK     (CLK),
    .RST     (RST),
    .start   (w_mulStart),
    .a       (w_opA),
    .b       (w_opB),
    .busy    (w_mulBusy),
    .done    (w_mulDone),
    .product (w_product)
  );

  // Single-cycle datapath: pick the write-back value and overflow cause for the opcode.
  always_comb begin
    w_aluWe    = 1'b0;
    w_aluData  = '0;
    w_aluOvSet = 1'b0;
    case (op)
      OP_ADD: begin
        w_aluWe    = 1'b1;
        w_aluData  = w_sum[WIDTH-1:0];
        w_aluOvSet = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_aluWe    = 1'b1;
        w_aluData  = w_diff[WIDTH-1:0];
        w_aluOvSet = w_diff[WIDTH];
      end
      OP_AND: begin
        w_aluWe   = 1'b1;
        w_aluData = w_opA & w_opB;
      end
      OP_OR: begin
        w_aluWe   = 1'b1;
        w_aluData = w_opA | w_opB;
      end
      OP_XOR: begin
        w_aluWe   = 1'b1;
        w_aluData = w_opA ^ w_opB;
      end
      OP_NOT: begin
        w_aluWe   = 1'b1;
        w_aluData = ~w_opA;
      end
      OP_SHL: begin
        w_aluWe   = 1'b1;
        w_aluData = w_opA << shamt;
      end
      OP_SHR: begin
        w_aluWe   = 1'b1;
        w_aluData = w_opA >> shamt;
      end
      OP_ASR: begin
        w_aluWe   = 1'b1;
        w_aluData = $signed(w_opA) >>> shamt;
      end
      default: begin
        w_aluWe = 1'b0;
      end
    endcase
  end

  // Merge the single-cycle and multiplier write-back paths; they never coincide
  // because nothing is accepted while the multiplier is running.
  always_comb begin
    w_wbEn   = 1'b0;
    w_wbIdx  = yindex;
    w_wbData = w_aluData;
    w_ovSet  = 1'b0;
    w_ovClr  = 1'b0;
    if (w_mulDone) begin
      w_wbEn   = 1'b1;
      w_wbIdx  = r_mulY;
      w_wbData = w_product[WIDTH-1:0];
      w_ovSet  = |w_product[2*WIDTH-1:WIDTH];
    end else if (w_accept) begin
      w_wbEn  = w_aluWe;
      w_ovSet = w_aluOvSet;
      w_ovClr = (op == OP_CLRF);
    end
  end

  // Controller state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Controller next state: stay in MUL until the multiplier retires.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (w_mulStart) w_stateNext = ST_MUL;
      ST_MUL:  if (w_mulDone)  w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Register file: external load first, so an ALU write to the same index overrides it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      if (ext_we) begin
        r_rf[ext_windex] <= ext_wdata;
      end
      if (w_wbEn) begin
        r_rf[w_wbIdx] <= w_wbData;
      end
    end
  end

  // Remember where the multiply result goes, since yindex may change meanwhile.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mulY <= '0;
    end else if (w_mulStart) begin
      r_mulY <= yindex;
    end
  end

  // Result, zero/negative track the last write-back; overflow is sticky until CLRF.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      if (w_wbEn) begin
        r_result        <= w_wbData;
        r_flags[FLAG_Z] <= (w_wbData == '0);
        r_flags[FLAG_N] <= w_wbData[WIDTH-1];
      end
      if (w_ovClr) begin
        r_flags[FLAG_OV] <= 1'b0;
      end else if (w_ovSet) begin
        r_flags[FLAG_OV] <= 1'b1;
      end
    end
  end

  // Retire pulse: one cycle after a non-MUL accept or after the multiply write-back.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (w_accept && (op != OP_MUL)) || w_mulDone;
    end
  end

  assign done      = r_done;
  assign result    = r_result;
  assign overflow  = r_flags[FLAG_OV];
  assign zero      = r_flags[FLAG_Z];
  assign negative  = r_flags[FLAG_N];
  assign ext_rdata = r_rf[ext_rindex];

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16, NREGS=8).
module tb_alu_seq;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [2:0]  aindex;
  logic [2:0]  bindex;
  logic [2:0]  yindex;
  logic [3:0]  shamt;
  logic        done;
  logic [15:0] result;
  logic        overflow;
  logic        zero;
  logic        negative;
  logic        ext_we;
  logic [2:0]  ext_windex;
  logic [15:0] ext_wdata;
  logic [2:0]  ext_rindex;
  logic [15:0] ext_rdata;

  int total = 0;
  int bad   = 0;

  alu_seq #(
    .WIDTH (16),
    .NREGS (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .aindex     (aindex),
    .bindex     (bindex),
    .yindex     (yindex),
    .shamt      (shamt),
    .done       (done),
    .result     (result),
    .overflow   (overflow),
    .zero       (zero),
    .negative   (negative),
    .ext_we     (ext_we),
    .ext_windex (ext_windex),
    .ext_wdata  (ext_wdata),
    .ext_rindex (ext_rindex),
    .ext_rdata  (ext_rdata)
  );

  // Free-running clock, 20 time units per cycle.
  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkReg(input string tag, input logic [2:0] idx,
                          input logic [15:0] expected);
    ext_rindex = idx;
    #1;
    checkOutput(tag, {16'h0, ext_rdata}, {16'h0, expected});
  endtask

  task automatic extWrite(input logic [2:0] idx, input logic [15:0] data);
    ext_we     = 1'b1;
    ext_windex = idx;
    ext_wdata  = data;
    tick();
    ext_we     = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] o, input logic [2:0] a,
                               input logic [2:0] b, input logic [2:0] y,
                               input logic [3:0] sh);
    in_valid = 1'b1;
    op       = o;
    aindex   = a;
    bindex   = b;
    yindex   = y;
    shamt    = sh;
    tick();
    in_valid = 1'b0;
    op       = 4'h0;
  endtask

  initial begin
    int cycles;
    int lowCnt;
    int doneCnt;

    RST        = 1'b1;
    in_valid   = 1'b0;
    op         = 4'h0;
    aindex     = '0;
    bindex     = '0;
    yindex     = '0;
    shamt      = '0;
    ext_we     = 1'b0;
    ext_windex = '0;
    ext_wdata  = '0;
    ext_rindex = '0;

    $display("[TB] reset");
    tick();
    tick();
    checkOutput("rst_ready", {31'h0, in_ready}, 32'd1);
    checkOutput("rst_done", {31'h0, done}, 32'd0);
    RST = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      checkReg($sformatf("rst_rf%0d", i), 3'(i), 16'h0000);
    end
    checkOutput("rst_ovf", {31'h0, overflow}, 32'd0);
    checkOutput("rst_result", {16'h0, result}, 32'h0);

    $display("[TB] ADD with carry, then CLRF");
    extWrite(3'd1, 16'hFFFF);
    extWrite(3'd2, 16'h0001);
    applyStimulus(4'h1, 3'd1, 3'd2, 3'd3, 4'd0);
    checkOutput("add_done", {31'h0, done}, 32'd1);
    checkOutput("add_result", {16'h0, result}, 32'h0);
    checkOutput("add_ovf", {31'h0, overflow}, 32'd1);
    checkOutput("add_zero", {31'h0, zero}, 32'd1);
    checkOutput("add_neg", {31'h0, negative}, 32'd0);
    checkReg("add_r3", 3'd3, 16'h0000);
    tick();
    checkOutput("add_done_pulse", {31'h0, done}, 32'd0);
    applyStimulus(4'hB, 3'd0, 3'd0, 3'd3, 4'd0);
    checkOutput("clrf_done", {31'h0, done}, 32'd1);
    checkOutput("clrf_ovf", {31'h0, overflow}, 32'd0);
    checkOutput("clrf_zero_hold", {31'h0, zero}, 32'd1);
    checkReg("clrf_r3", 3'd3, 16'h0000);

    $display("[TB] SUB with borrow");
    extWrite(3'd5, 16'h0005);
    extWrite(3'd6, 16'h0007);
    applyStimulus(4'h2, 3'd5, 3'd6, 3'd7, 4'd0);
    checkReg("sub_r7", 3'd7, 16'hFFFE);
    checkOutput("sub_neg", {31'h0, negative}, 32'd1);
    checkOutput("sub_ovf", {31'h0, overflow}, 32'd1);
    checkOutput("sub_zero", {31'h0, zero}, 32'd0);

    $display("[TB] shifts keep overflow");
    extWrite(3'd1, 16'h0001);
    applyStimulus(4'h7, 3'd1, 3'd0, 3'd2, 4'd15);
    checkReg("shl_r2", 3'd2, 16'h8000);
    applyStimulus(4'h8, 3'd2, 3'd0, 3'd3, 4'd3);
    checkReg("shr_r3", 3'd3, 16'h1000);
    applyStimulus(4'h9, 3'd2, 3'd0, 3'd4, 4'd3);
    checkReg("asr_r4", 3'd4, 16'hF000);
    checkOutput("asr_neg", {31'h0, negative}, 32'd1);
    checkOutput("shift_ovf_hold", {31'h0, overflow}, 32'd1);

    $display("[TB] logic ops");
    applyStimulus(4'h3, 3'd5, 3'd6, 3'd0, 4'd0);
    checkReg("and_r0", 3'd0, 16'h0005);
    applyStimulus(4'h4, 3'd5, 3'd6, 3'd0, 4'd0);
    checkReg("or_r0", 3'd0, 16'h0007);
    applyStimulus(4'h5, 3'd5, 3'd6, 3'd0, 4'd0);
    checkReg("xor_r0", 3'd0, 16'h0002);
    applyStimulus(4'h6, 3'd5, 3'd0, 3'd0, 4'd0);
    checkReg("not_r0", 3'd0, 16'hFFFA);
    applyStimulus(4'hE, 3'd5, 3'd6, 3'd0, 4'd0);
    checkOutput("nop_e_done", {31'h0, done}, 32'd1);
    checkReg("nop_e_r0", 3'd0, 16'hFFFA);
    applyStimulus(4'hB, 3'd0, 3'd0, 3'd0, 4'd0);
    checkOutput("clrf2_ovf", {31'h0, overflow}, 32'd0);

    $display("[TB] MUL 3*5");
    extWrite(3'd1, 16'h0003);
    extWrite(3'd2, 16'h0005);
    applyStimulus(4'hA, 3'd1, 3'd2, 3'd3, 4'd0);
    checkOutput("mul1_done_early", {31'h0, done}, 32'd0);
    cycles = 0;
    lowCnt = 0;
    while (!done && cycles < 40) begin
      if (!in_ready) lowCnt++;
      tick();
      cycles++;
    end
    checkOutput("mul1_latency", cycles, 32'd16);
    checkOutput("mul1_ready_low", lowCnt, 32'd16);
    checkOutput("mul1_ready_back", {31'h0, in_ready}, 32'd1);
    checkOutput("mul1_result", {16'h0, result}, 32'h000F);
    checkOutput("mul1_ovf", {31'h0, overflow}, 32'd0);
    checkReg("mul1_r3", 3'd3, 16'h000F);
    tick();
    checkOutput("mul1_done_pulse", {31'h0, done}, 32'd0);

    $display("[TB] MUL overflow, held request, operand overwrite");
    extWrite(3'd1, 16'h0100);
    extWrite(3'd2, 16'h0100);
    applyStimulus(4'hA, 3'd1, 3'd2, 3'd6, 4'd0);
    in_valid = 1'b1;
    op       = 4'h1;
    aindex   = 3'd1;
    bindex   = 3'd1;
    yindex   = 3'd7;
    cycles = 0;
    lowCnt = 0;
    while (!done && cycles < 40) begin
      if (!in_ready) lowCnt++;
      ext_we     = (cycles == 3);
      ext_windex = 3'd1;
      ext_wdata  = 16'h0003;
      tick();
      cycles++;
    end
    ext_we = 1'b0;
    checkOutput("mul2_latency", cycles, 32'd16);
    checkOutput("mul2_ready_low", lowCnt, 32'd16);
    checkOutput("mul2_result", {16'h0, result}, 32'h0000);
    checkOutput("mul2_ovf", {31'h0, overflow}, 32'd1);
    checkOutput("mul2_zero", {31'h0, zero}, 32'd1);
    checkReg("mul2_r6", 3'd6, 16'h0000);
    checkReg("mul2_ext_r1", 3'd1, 16'h0003);
    checkReg("mul2_held_r7", 3'd7, 16'hFFFE);
    tick();
    in_valid = 1'b0;
    op       = 4'h0;
    checkOutput("held_add_done", {31'h0, done}, 32'd1);
    checkOutput("held_add_result", {16'h0, result}, 32'h0006);
    checkReg("held_add_r7", 3'd7, 16'h0006);
    checkOutput("held_add_ovf", {31'h0, overflow}, 32'd1);

    $display("[TB] write conflicts");
    ext_we     = 1'b1;
    ext_windex = 3'd4;
    ext_wdata  = 16'h1234;
    applyStimulus(4'h1, 3'd5, 3'd5, 3'd4, 4'd0);
    ext_we = 1'b0;
    checkReg("conflict_r4", 3'd4, 16'h000A);
    ext_we     = 1'b1;
    ext_windex = 3'd0;
    ext_wdata  = 16'hBEEF;
    applyStimulus(4'h1, 3'd5, 3'd1, 3'd4, 4'd0);
    ext_we = 1'b0;
    checkReg("dual_r0", 3'd0, 16'hBEEF);
    checkReg("dual_r4", 3'd4, 16'h0008);

    $display("[TB] reset during MUL");
    applyStimulus(4'hA, 3'd5, 3'd5, 3'd2, 4'd0);
    for (int i = 0; i < 5; i++) tick();
    RST = 1'b1;
    #1;
    checkOutput("mulrst_ready", {31'h0, in_ready}, 32'd1);
    checkOutput("mulrst_done", {31'h0, done}, 32'd0);
    tick();
    RST = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) doneCnt++;
      tick();
    end
    checkOutput("mulrst_no_done", doneCnt, 32'd0);
    checkOutput("mulrst_ready_after", {31'h0, in_ready}, 32'd1);
    checkOutput("mulrst_result", {16'h0, result}, 32'h0);
    checkOutput("mulrst_ovf", {31'h0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      checkReg($sformatf("mulrst_rf%0d", i), 3'(i), 16'h0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
